// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default panel geometry and panel FSM state encoding.
package elevator_pkg;

  localparam int unsigned DEF_NUM_FLOORS     = 8;
  localparam int unsigned DEF_FLOOR_W        = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_OFFER = 2'd1,
    P_WAIT  = 2'd2
  } panel_state_e;

endpackage

// File: rtl/scan_target_select.sv
// SCAN target picker: keeps the current direction while a request lies ahead,
// otherwise reverses and takes the nearest request behind.
// Ports:
//   pending     in   NUM_FLOORS  latched floor requests
//   car_floor   in   FLOOR_W     current car floor
//   dir_up      in   1           current direction, 1 = up
//   found       out  1           at least one request pending
//   target      out  FLOOR_W     chosen floor (0 when nothing pending)
//   next_dir_up out  1           direction after selection
module scan_target_select
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  dir_up,
  output logic                  found,
  output logic [FLOOR_W-1:0]    target,
  output logic                  next_dir_up
);

  logic               lo_ge_found, lo_gt_found, hi_le_found, hi_lt_found;
  logic [FLOOR_W-1:0] lo_ge, lo_gt, hi_le, hi_lt;

  // Descending scan leaves the lowest match; ascending scan leaves the highest.
  always_comb begin
    lo_ge_found = 1'b0;
    lo_gt_found = 1'b0;
    hi_le_found = 1'b0;
    hi_lt_found = 1'b0;
    lo_ge       = '0;
    lo_gt       = '0;
    hi_le       = '0;
    hi_lt       = '0;
    for (int f = int'(NUM_FLOORS) - 1; f >= 0; f--) begin
      if (pending[f] && (FLOOR_W'(f) >= car_floor)) begin
        lo_ge_found = 1'b1;
        lo_ge       = FLOOR_W'(f);
      end
      if (pending[f] && (FLOOR_W'(f) > car_floor)) begin
        lo_gt_found = 1'b1;
        lo_gt       = FLOOR_W'(f);
      end
    end
    for (int f = 0; f < int'(NUM_FLOORS); f++) begin
      if (pending[f] && (FLOOR_W'(f) <= car_floor)) begin
        hi_le_found = 1'b1;
        hi_le       = FLOOR_W'(f);
      end
      if (pending[f] && (FLOOR_W'(f) < car_floor)) begin
        hi_lt_found = 1'b1;
        hi_lt       = FLOOR_W'(f);
      end
    end
  end

  // Direction decision; a non-empty pending set always yields a target on one side.
  always_comb begin
    found       = |pending;
    target      = '0;
    next_dir_up = dir_up;
    if (found) begin
      if (dir_up) begin
        if (lo_ge_found) begin
          target      = lo_ge;
          next_dir_up = 1'b1;
        end else begin
          target      = hi_lt;
          next_dir_up = hi_lt_found ? 1'b0 : dir_up;
        end
      end else begin
        if (hi_le_found) begin
          target      = hi_le;
          next_dir_up = 1'b0;
        end else begin
          target      = lo_gt;
          next_dir_up = lo_gt_found ? 1'b1 : dir_up;
        end
      end
    end
  end

endmodule

// File: rtl/floor_request_panel.sv
// Floor request panel: synchronises and latches button presses, offers the
// SCAN-selected target to the car over valid/ready, and clears requests on arrival.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   btn            raw asynchronous button levels, bit f = floor f
//   car_floor      current car floor
//   car_arrived    1-cycle pulse, car stopped at car_floor
//   req_ready      car accepts req_floor
//   req_valid      target offer valid
//   req_floor      target floor, stable while req_valid
//   pending        latched requests (lamps)
//   dir_up         current SCAN direction, 1 = up
//   timeout_fault  1-cycle pulse on arrival watchdog expiry
module floor_request_panel
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS     = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W        = DEF_FLOOR_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_arrived,
  input  logic                  req_ready,
  output logic                  req_valid,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  timeout_fault
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CMP_W = FLOOR_W + 1;

  panel_state_e state, state_nxt;

  logic [NUM_FLOORS-1:0] sync1, sync2, sync3;
  logic [NUM_FLOORS-1:0] rise, clr_mask, pending_nxt, pend_shift;
  logic [WD_W-1:0]       wd, wd_nxt;
  logic                  tgt_pending, arrive_at_req, wd_expired;
  logic                  found, next_dir_up;
  logic [FLOOR_W-1:0]    target;
  logic                  req_valid_nxt, dir_up_nxt, timeout_nxt;
  logic [FLOOR_W-1:0]    req_floor_nxt;

  scan_target_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan (
    .pending     (pending),
    .car_floor   (car_floor),
    .dir_up      (dir_up),
    .found       (found),
    .target      (target),
    .next_dir_up (next_dir_up)
  );

  // Press/clear path: a clear on the same floor in the same cycle beats the press.
  always_comb begin
    rise     = sync2 & ~sync3;
    clr_mask = '0;
    if (car_arrived && ({1'b0, car_floor} < CMP_W'(NUM_FLOORS))) begin
      clr_mask = NUM_FLOORS'(1) << car_floor;
    end
    pending_nxt   = (pending | rise) & ~clr_mask;
    pend_shift    = pending >> req_floor;
    tgt_pending   = pend_shift[0];
    arrive_at_req = car_arrived && (car_floor == req_floor);
    wd_expired    = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= P_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      P_IDLE: begin
        if (found) state_nxt = P_OFFER;
      end
      P_OFFER: begin
        if (!tgt_pending)   state_nxt = P_IDLE;
        else if (req_ready) state_nxt = P_WAIT;
      end
      P_WAIT: begin
        if (arrive_at_req || !tgt_pending) state_nxt = P_IDLE;
        else if (wd_expired)               state_nxt = P_OFFER;
      end
      default: state_nxt = P_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the watchdog.
  always_comb begin
    req_valid_nxt = (state_nxt == P_OFFER);
    req_floor_nxt = req_floor;
    dir_up_nxt    = dir_up;
    timeout_nxt   = (state == P_WAIT) && (state_nxt == P_OFFER);
    wd_nxt        = '0;
    if ((state == P_IDLE) && found) begin
      req_floor_nxt = target;
      dir_up_nxt    = next_dir_up;
    end
    if ((state == P_WAIT) && (state_nxt == P_WAIT)) begin
      wd_nxt = wd + 1'b1;
    end
  end

  // Datapath registers: synchroniser, lamps, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      sync3         <= '0;
      pending       <= '0;
      wd            <= '0;
      req_valid     <= 1'b0;
      req_floor     <= '0;
      dir_up        <= 1'b1;
      timeout_fault <= 1'b0;
    end else begin
      sync1         <= btn;
      sync2         <= sync1;
      sync3         <= sync2;
      pending       <= pending_nxt;
      wd            <= wd_nxt;
      req_valid     <= req_valid_nxt;
      req_floor     <= req_floor_nxt;
      dir_up        <= dir_up_nxt;
      timeout_fault <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_floor_request_panel.sv
// Directed bench for floor_request_panel with an 8-cycle arrival watchdog.
module tb_floor_request_panel;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn;
  logic [3:0] car_floor;
  logic       car_arrived;
  logic       req_ready;
  logic       req_valid;
  logic [3:0] req_floor;
  logic [7:0] pending;
  logic       dir_up;
  logic       timeout_fault;

  int checks   = 0;
  int failures = 0;

  floor_request_panel #(
    .NUM_FLOORS     (8),
    .FLOOR_W        (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .car_floor     (car_floor),
    .car_arrived   (car_arrived),
    .req_ready     (req_ready),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .pending       (pending),
    .dir_up        (dir_up),
    .timeout_fault (timeout_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; btn = '0; car_floor = '0; car_arrived = 1'b0; req_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_floor", 32'(req_floor), 32'd0);
    chk("rst_pending",   32'(pending),   32'h00);
    chk("rst_dir_up",    32'(dir_up),    32'd1);
    chk("rst_timeout",   32'(timeout_fault), 32'd0);

    // Press floor 5 with car at 0: lamp two edges after the first sampling edge.
    btn = 8'h20;
    step(); step();
    chk("t1_pending_early", 32'(pending), 32'h00);
    step();
    chk("t1_pending", 32'(pending), 32'h20);
    chk("t1_valid_not_yet", 32'(req_valid), 32'd0);
    btn = 8'h00;
    step();
    chk("t1_req_valid", 32'(req_valid), 32'd1);
    chk("t1_req_floor", 32'(req_floor), 32'd5);
    chk("t1_dir_up",    32'(dir_up),    32'd1);
    step(); step(); step(); step();
    chk("t1_hold_valid", 32'(req_valid), 32'd1);
    chk("t1_hold_floor", 32'(req_floor), 32'd5);

    // Pass-through arrival at the offered floor before acceptance drops the offer.
    car_floor = 4'd5; car_arrived = 1'b1;
    step();
    car_arrived = 1'b0;
    chk("t1_clear_pending", 32'(pending), 32'h00);
    chk("t1_still_offer",   32'(req_valid), 32'd1);
    step();
    chk("t1_drop_idle", 32'(req_valid), 32'd0);

    // Car at 3 going up with requests {1,6}: take 6, then reverse to 1.
    car_floor = 4'd3;
    btn = 8'h42;
    step(); step(); step();
    chk("t2_pending", 32'(pending), 32'h42);
    step();
    chk("t2_req_floor", 32'(req_floor), 32'd6);
    chk("t2_dir_up",    32'(dir_up),    32'd1);
    btn = 8'h00;
    car_floor = 4'd6; car_arrived = 1'b1;
    step();
    car_arrived = 1'b0;
    chk("t2_pending_after6", 32'(pending), 32'h02);
    step(); step();
    chk("t2_req_valid", 32'(req_valid), 32'd1);
    chk("t2_req_floor1", 32'(req_floor), 32'd1);
    chk("t2_dir_down",   32'(dir_up),    32'd0);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("t2_accepted", 32'(req_valid), 32'd0);
    car_floor = 4'd1; car_arrived = 1'b1;
    step();
    car_arrived = 1'b0;
    chk("t2_arrived1", 32'(pending), 32'h00);

    // Accept 6, then an intermediate stop at 4 clears only floor 4.
    btn = 8'h40;
    step(); step(); step();
    btn = 8'h00;
    step();
    chk("t3_req_floor", 32'(req_floor), 32'd6);
    chk("t3_dir_up",    32'(dir_up),    32'd1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    btn = 8'h10;
    step(); step(); step();
    chk("t3_pending", 32'(pending), 32'h50);
    chk("t3_no_retarget", 32'(req_valid), 32'd0);
    car_floor = 4'd4; car_arrived = 1'b1;
    step();
    car_arrived = 1'b0;
    chk("t3_clear4", 32'(pending), 32'h40);
    step();
    chk("t3_still_wait", 32'(req_valid), 32'd0);
    car_floor = 4'd6; car_arrived = 1'b1;
    step();
    car_arrived = 1'b0;
    chk("t3_arrive6", 32'(pending), 32'h00);
    step(); step();
    chk("t3_idle_valid",   32'(req_valid), 32'd0);
    chk("t3_idle_timeout", 32'(timeout_fault), 32'd0);

    // Watchdog: accept 7 and never arrive.
    btn = 8'h80;
    step(); step(); step(); step();
    chk("t4_req_floor", 32'(req_floor), 32'd7);
    chk("t4_req_valid", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("t4_wait_%0d", i), 32'({timeout_fault, req_valid}), 32'd0);
    end
    step();
    chk("t4_timeout",   32'(timeout_fault), 32'd1);
    chk("t4_reoffer",   32'(req_valid), 32'd1);
    chk("t4_same_flr",  32'(req_floor), 32'd7);
    step();
    chk("t4_pulse_end", 32'(timeout_fault), 32'd0);
    chk("t4_offer_hold", 32'(req_valid), 32'd1);

    // Floor-2 press edge lands on the same cycle as arrival at floor 2.
    btn = 8'h84;
    step(); step();
    car_floor = 4'd2; car_arrived = 1'b1;
    step();
    car_arrived = 1'b0;
    chk("t5_clear_wins", 32'(pending), 32'h80);
    step(); step(); step(); step();
    chk("t5_held_no_reset", 32'(pending), 32'h80);

    // Reset while waiting with every lamp lit.
    btn = 8'h00;
    step(); step(); step();
    btn = 8'hFF;
    step(); step(); step();
    chk("t6_pending_ff", 32'(pending), 32'hFF);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("t6_in_wait", 32'(req_valid), 32'd0);
    reset = 1'b1; btn = 8'h00;
    step();
    chk("t6_req_valid", 32'(req_valid), 32'd0);
    chk("t6_req_floor", 32'(req_floor), 32'd0);
    chk("t6_pending",   32'(pending),   32'h00);
    chk("t6_dir_up",    32'(dir_up),    32'd1);
    chk("t6_timeout",   32'(timeout_fault), 32'd0);
    reset = 1'b0;
    step();
    chk("t6_post_pending", 32'(pending), 32'h00);
    chk("t6_post_valid",   32'(req_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
